// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access path.
//   ADDR_W_DEF / DATA_W_DEF / STARVE_MAX_DEF : default geometry and fairness bound
//   state_t : arbiter sequencing state (IDLE, RD_WAIT)
//   owner_t : which requester owns the read that is in flight
package dmem_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 32;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

endpackage

// File: rtl/data_sram.sv
// Single-port synchronous data memory, 2**ADDR_W words of DATA_W bits.
// Ports:
//   clk      in   clock
//   i_en     in   access enable for this cycle
//   i_we     in   1 = write i_wdata to i_addr, 0 = read i_addr
//   i_addr   in   word address
//   i_wdata  in   write data
//   o_rdata  out  read data, valid the cycle after a read access
module data_sram
    import dmem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the array and its read register carry no reset so they map onto a
    // RAM macro; software must write a location before reading it.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_arbiter.sv
// Access controller sharing the single-port data memory between the pipeline
// Memory stage (cpu*) and the program/debug loader (dbg*).
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpuReq/We/Addr/Wdata           Memory-stage request; fields sampled at grant
//   cpuReady                       grant (combinational)
//   cpuRvalid/cpuRdata             registered load return, one-cycle valid pulse
//   stall                          cpuReq & ~cpuReady, freezes the pipeline
//   dbgReq/We/Addr/Wdata/Ready/Rvalid/Rdata   loader side, same meaning
//   memEn/memWe/memAddr/memWdata   drive the data_sram this cycle
//   memRdata                       RAM read data, one cycle after a read
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWdata,
    output logic              cpuReady,
    output logic              cpuRvalid,
    output logic [DATA_W-1:0] cpuRdata,
    output logic              stall,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    output logic              dbgReady,
    output logic              dbgRvalid,
    output logic [DATA_W-1:0] dbgRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t            r_state;
    owner_t            r_owner;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_cpu_rvalid;
    logic              r_dbg_rvalid;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [DATA_W-1:0] r_dbg_rdata;

    logic w_idle;
    logic w_dbg_first;
    logic w_grant_cpu;
    logic w_grant_dbg;

    // Grants are qualified with rst_n so every combinational output is 0 while
    // reset is held, even with requests asserted.
    always_comb begin
        w_idle      = rst_n && (r_state == IDLE);
        w_dbg_first = (r_starve_cnt == CNT_MAX);
        w_grant_cpu = w_idle && cpuReq && !(dbgReq && w_dbg_first);
        w_grant_dbg = w_idle && dbgReq && !w_grant_cpu;
    end

    // NOTE: every signal written in this always_comb gets a default first so no
    // latch is inferred on the cycles with no grant.
    always_comb begin
        memEn    = 1'b0;
        memWe    = 1'b0;
        memAddr  = '0;
        memWdata = '0;
        if (w_grant_cpu) begin
            memEn    = 1'b1;
            memWe    = cpuWe;
            memAddr  = cpuAddr;
            memWdata = cpuWdata;
        end else if (w_grant_dbg) begin
            memEn    = 1'b1;
            memWe    = dbgWe;
            memAddr  = dbgAddr;
            memWdata = dbgWdata;
        end
    end

    assign cpuReady  = w_grant_cpu;
    assign dbgReady  = w_grant_dbg;
    assign stall     = rst_n && cpuReq && !w_grant_cpu;
    assign cpuRvalid = r_cpu_rvalid;
    assign dbgRvalid = r_dbg_rvalid;
    assign cpuRdata  = r_cpu_rdata;
    assign dbgRdata  = r_dbg_rdata;

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_CPU;
            r_starve_cnt <= '0;
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;
            r_cpu_rdata  <= '0;
            r_dbg_rdata  <= '0;
        end else begin
            r_cpu_rvalid <= 1'b0;
            r_dbg_rvalid <= 1'b0;

            // Counts cpu grants that overtook a waiting loader; saturates so the
            // loader wins the next contended cycle.
            if (!dbgReq || w_grant_dbg) begin
                r_starve_cnt <= '0;
            end else if (w_grant_cpu && (r_starve_cnt != CNT_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if ((w_grant_cpu && !cpuWe) || (w_grant_dbg && !dbgWe)) begin
                        r_state <= RD_WAIT;
                        r_owner <= w_grant_dbg ? OWN_DBG : OWN_CPU;
                    end
                end
                RD_WAIT: begin
                    r_state <= IDLE;
                    if (r_owner == OWN_DBG) begin
                        r_dbg_rdata  <= memRdata;
                        r_dbg_rvalid <= 1'b1;
                    end else begin
                        r_cpu_rdata  <= memRdata;
                        r_cpu_rvalid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W     = 8;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;
    localparam int TIMEOUT    = 40;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpuReq, cpuWe, dbgReq, dbgWe;
    logic [ADDR_W-1:0] cpuAddr, dbgAddr;
    logic [DATA_W-1:0] cpuWdata, dbgWdata;
    logic              cpuReady, cpuRvalid, stall, dbgReady, dbgRvalid;
    logic [DATA_W-1:0] cpuRdata, dbgRdata;
    logic              memEn, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWdata, memRdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuReady(cpuReady), .cpuRvalid(cpuRvalid), .cpuRdata(cpuRdata), .stall(stall),
        .dbgReq(dbgReq), .dbgWe(dbgWe), .dbgAddr(dbgAddr), .dbgWdata(dbgWdata),
        .dbgReady(dbgReady), .dbgRvalid(dbgRvalid), .dbgRdata(dbgRdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata)
    );

    data_sram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_sram (
        .clk(clk), .i_en(memEn), .i_we(memWe), .i_addr(memAddr),
        .i_wdata(memWdata), .o_rdata(memRdata)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        int          due;
        logic [31:0] data;
    } ret_t;

    logic [DATA_W-1:0] ref_mem [256];
    ret_t              cpu_q[$];
    ret_t              dbg_q[$];
    logic [DATA_W-1:0] exp_cpu_rd, exp_dbg_rd;
    int                cyc = 0;
    int                busy = 0;     // cycles the memory is still occupied by a read
    int                consec = 0;   // cpu grants taken while the loader waited

    always @(negedge clk) begin
        logic exp_c, exp_d;
        if (!rst_n) begin
            check("rst_cpuReady", cpuReady, 0);
            check("rst_dbgReady", dbgReady, 0);
            check("rst_stall", stall, 0);
            check("rst_memEn", memEn, 0);
            check("rst_cpuRvalid", cpuRvalid, 0);
            check("rst_dbgRvalid", dbgRvalid, 0);
            check("rst_cpuRdata", cpuRdata, 0);
            check("rst_dbgRdata", dbgRdata, 0);
            cpu_q.delete();
            dbg_q.delete();
            exp_cpu_rd = '0;
            exp_dbg_rd = '0;
            busy       = 0;
            consec     = 0;
        end else begin
            exp_c = 1'b0;
            exp_d = 1'b0;
            if (busy == 0) begin
                if (cpuReq && dbgReq) begin
                    if (consec >= STARVE_MAX) exp_d = 1'b1;
                    else                      exp_c = 1'b1;
                end else begin
                    exp_c = cpuReq;
                    exp_d = dbgReq;
                end
            end
            check("cpuReady", cpuReady, exp_c);
            check("dbgReady", dbgReady, exp_d);
            check("stall", stall, cpuReq && !exp_c);
            check("memEn", memEn, exp_c || exp_d);
            if (exp_c) begin
                check("memWe_cpu", memWe, cpuWe);
                check("memAddr_cpu", memAddr, cpuAddr);
            end else if (exp_d) begin
                check("memWe_dbg", memWe, dbgWe);
                check("memAddr_dbg", memAddr, dbgAddr);
            end

            if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                check("cpuRvalid_pulse", cpuRvalid, 1);
                exp_cpu_rd = cpu_q[0].data;
                void'(cpu_q.pop_front());
            end else begin
                check("cpuRvalid_idle", cpuRvalid, 0);
            end
            check("cpuRdata", cpuRdata, exp_cpu_rd);

            if (dbg_q.size() > 0 && dbg_q[0].due == cyc) begin
                check("dbgRvalid_pulse", dbgRvalid, 1);
                exp_dbg_rd = dbg_q[0].data;
                void'(dbg_q.pop_front());
            end else begin
                check("dbgRvalid_idle", dbgRvalid, 0);
            end
            check("dbgRdata", dbgRdata, exp_dbg_rd);

            if (busy > 0) busy--;
            if (exp_c) begin
                if (dbgReq) consec++;
                if (cpuWe) ref_mem[cpuAddr] = cpuWdata;
                else begin
                    cpu_q.push_back('{due: cyc + 2, data: ref_mem[cpuAddr]});
                    busy = 1;
                end
            end
            if (exp_d) begin
                consec = 0;
                if (dbgWe) ref_mem[dbgAddr] = dbgWdata;
                else begin
                    dbg_q.push_back('{due: cyc + 2, data: ref_mem[dbgAddr]});
                    busy = 1;
                end
            end
            if (!dbgReq) consec = 0;
            cyc++;
        end
    end

    // ---------------- drivers ----------------
    task automatic cpu_do(input logic we, input logic [7:0] a, input logic [31:0] d,
                          input bit cancel, output int waited);
        bit granted = 1'b0;
        cpuReq = 1'b1; cpuWe = we; cpuAddr = a; cpuWdata = d;
        waited = 0;
        while (!granted && waited <= TIMEOUT) begin
            @(negedge clk);
            if (cpuReady) granted = 1'b1;
            else begin
                waited++;
                if (cancel) break;
            end
        end
        if (!cancel) check("cpu_grant_timeout", granted, 1);
        @(posedge clk); #1;
        cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    endtask

    task automatic dbg_do(input logic we, input logic [7:0] a, input logic [31:0] d,
                          input bit cancel, output int waited);
        bit granted = 1'b0;
        dbgReq = 1'b1; dbgWe = we; dbgAddr = a; dbgWdata = d;
        waited = 0;
        while (!granted && waited <= TIMEOUT) begin
            @(negedge clk);
            if (dbgReady) granted = 1'b1;
            else begin
                waited++;
                if (cancel) break;
            end
        end
        if (!cancel) check("dbg_grant_timeout", granted, 1);
        @(posedge clk); #1;
        dbgReq = 1'b0; dbgWe = 1'b0; dbgAddr = '0; dbgWdata = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w_c, w_d;
        // Reset with both requesters active: nothing may be granted.
        rst_n = 1'b0;
        cpuReq = 1'b1; cpuWe = 1'b1; cpuAddr = 8'h33; cpuWdata = 32'h1234_5678;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 8'h34; dbgWdata = 32'hCAFE_0001;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;              // first contended cycle must go to cpu
        @(posedge clk); #1;
        cpuReq = 1'b0; dbgReq = 1'b0;  // loader drops its request: legal cancel

        // Fill every word so later random loads read defined data.
        for (int a = 0; a < 256; a++) cpu_do(1'b1, 8'(a), $urandom, 1'b0, w_c);

        // Store then load the same word.
        cpu_do(1'b1, 8'h10, 32'hDEAD_BEEF, 1'b0, w_c);
        cpu_do(1'b0, 8'h10, 32'h0, 1'b0, w_c);
        repeat (3) begin @(posedge clk); #1; end

        // Both requesters saturated with stores: loader bounded by STARVE_MAX.
        fork
            for (int i = 0; i < 16; i++) cpu_do(1'b1, 8'(8'h80 + i), $urandom, 1'b0, w_c);
            for (int i = 0; i < 3; i++) begin
                int w;
                dbg_do(1'b1, 8'(8'hC0 + i), $urandom, 1'b0, w);
                check("dbg_wait_bound", 32'(w <= STARVE_MAX), 1);
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        // Loader read in flight while the pipeline issues a load: cpu stalls.
        fork
            dbg_do(1'b0, 8'h05, 32'h0, 1'b0, w_d);
            begin
                @(posedge clk); #1;
                cpu_do(1'b0, 8'h20, 32'h0, 1'b0, w_c);
            end
        join
        repeat (3) begin @(posedge clk); #1; end

        // Reset during RD_WAIT: the pending return is dropped.
        cpu_do(1'b0, 8'h44, 32'h0, 1'b0, w_c);
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        cpu_do(1'b0, 8'h44, 32'h0, 1'b0, w_c);
        repeat (3) begin @(posedge clk); #1; end

        // Top address must not alias word 0.
        cpu_do(1'b1, 8'hFF, 32'hA5A5_0FF0, 1'b0, w_c);
        cpu_do(1'b1, 8'h00, 32'h5A5A_1001, 1'b0, w_c);
        cpu_do(1'b0, 8'hFF, 32'h0, 1'b0, w_c);
        cpu_do(1'b0, 8'h00, 32'h0, 1'b0, w_c);
        repeat (3) begin @(posedge clk); #1; end

        // Randomised traffic from both sides, with gaps and cancels.
        fork
            for (int i = 0; i < 200; i++) begin
                int w;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                cpu_do(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                       ($urandom_range(0, 7) == 0), w);
            end
            for (int i = 0; i < 120; i++) begin
                int w;
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                dbg_do(1'($urandom_range(0, 1)), 8'($urandom), $urandom,
                       ($urandom_range(0, 7) == 0), w);
            end
        join

        repeat (4) @(negedge clk);
        check("cpu_returns_drained", 32'(cpu_q.size()), 0);
        check("dbg_returns_drained", 32'(dbg_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
